// File: rtl/i2s_pkg.sv
// Shared I2S frame-format constants and channel tag, used by the transmitter and receiver.
package i2s_pkg;

    localparam int SLOT_W      = 32;
    localparam int SAMPLE_W    = 24;
    localparam int FRAME_SLOTS = 2;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } chan_e;

    // Left-justified sample bits of a slot word; the padding below the sample always goes out as 0.
    localparam logic [SLOT_W-1:0] LANE_MASK = {{SAMPLE_W{1'b1}}, {(SLOT_W-SAMPLE_W){1'b0}}};

endpackage

// File: rtl/i2s_tx_if.sv
// AXI-Stream audio beat carrying one 32-bit lane per SD line, with tuser as the channel tag.
interface i2s_tx_if #(
    parameter int SD_LINES = 2
);
    logic [32*SD_LINES-1:0] tdata;
    logic                   tvalid;
    logic                   tready;
    logic                   tuser;

    modport master (output tdata, output tvalid, output tuser, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tuser, output tready);
endinterface

// File: rtl/i2s_sck_gen.sv
// Bit-clock generator: SCK half-period of CLK_DIV clk cycles, plus a strobe on the clk where SCK falls.
module i2s_sck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rstn,
    output logic sck,
    output logic fall
);
    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_cnt;
    logic          wrap;

    assign wrap = (div_cnt == DW'(CLK_DIV - 1));
    assign fall = wrap & sck;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            div_cnt <= '0;
            sck     <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            sck     <= ~sck;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/i2s_tx.sv
// I2S master transmitter: one-word AXIS buffer, per-line shift registers, WS/SD generation.
// Optional I2S_TX_ERR_CNT_EN adds saturating underrun_cnt / chan_err_cnt outputs.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int SD_LINES = 2
) (
    input  logic                clk,
    input  logic                rstn,
    i2s_tx_if.slave             s_axis,
    output logic                SCK,
    output logic                WS,
    output logic [SD_LINES-1:0] SD,
    output logic                underrun,
    output logic                chan_err
`ifdef I2S_TX_ERR_CNT_EN
    ,
    output logic [15:0]         underrun_cnt,
    output logic [15:0]         chan_err_cnt
`endif
);
    localparam int BW = $clog2(SLOT_W);

    logic                             fall;
    logic [BW-1:0]                    bit_cnt;
    logic [BW-1:0]                    sd_idx;
    logic [SD_LINES-1:0][SLOT_W-1:0]  buf_data;
    logic [SD_LINES-1:0][SLOT_W-1:0]  sh;
    chan_e                            buf_user;
    logic                             full;
    logic                             rdy_en;
    logic                             accept;
    logic                             slot_start;
    logic                             tag_ok;

    i2s_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk  (clk),
        .rstn (rstn),
        .sck  (SCK),
        .fall (fall)
    );

    assign s_axis.tready = rdy_en & ~full;
    assign accept        = s_axis.tvalid & s_axis.tready;
    assign slot_start    = fall & (bit_cnt == '0);
    assign tag_ok        = (buf_user == chan_e'(~WS));

    // Bit 32-k modulo 32: k=0 replays bit 0 of the outgoing word, k=1..31 walks 31 down to 1.
    assign sd_idx = BW'(0) - bit_cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            bit_cnt  <= '0;
            WS       <= 1'b1;
            SD       <= '0;
            sh       <= '0;
            buf_data <= '0;
            buf_user <= CH_LEFT;
            full     <= 1'b0;
            rdy_en   <= 1'b0;
            underrun <= 1'b0;
            chan_err <= 1'b0;
        end else begin
            rdy_en   <= 1'b1;
            underrun <= 1'b0;
            chan_err <= 1'b0;

            // tready is only high while empty, so a fill and a slot-start drain never coincide.
            if (accept) begin
                for (int unsigned n = 0; n < SD_LINES; n++)
                    buf_data[n] <= s_axis.tdata[n*SLOT_W +: SLOT_W] & LANE_MASK;
                buf_user <= chan_e'(s_axis.tuser);
                full     <= 1'b1;
            end

            if (fall) begin
                bit_cnt <= bit_cnt + 1'b1;
                for (int unsigned n = 0; n < SD_LINES; n++)
                    SD[n] <= sh[n][sd_idx];
            end

            if (slot_start) begin
                WS       <= ~WS;
                sh       <= (full && tag_ok) ? buf_data : '0;
                underrun <= ~full;
                chan_err <= full & ~tag_ok;
                if (full)
                    full <= 1'b0;
            end
        end
    end

`ifdef I2S_TX_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            underrun_cnt <= '0;
            chan_err_cnt <= '0;
        end else begin
            if (underrun && underrun_cnt != '1)
                underrun_cnt <= underrun_cnt + 16'd1;
            if (chan_err && chan_err_cnt != '1)
                chan_err_cnt <= chan_err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: SD is deserialised on SCK rising edges and compared slot by slot
// against a queue of expected words pushed as beats are driven.
module tb_i2s_tx;

    localparam int CLK_DIV  = 4;
    localparam int SD_LINES = 2;
    localparam int SLOT_CLK = 32 * 2 * CLK_DIV;
    localparam int FIRST    = 2 * CLK_DIV;

    logic                clk;
    logic                rstn;
    logic                SCK;
    logic                WS;
    logic [SD_LINES-1:0] SD;
    logic                underrun;
    logic                chan_err;
`ifdef I2S_TX_ERR_CNT_EN
    logic [15:0]         underrun_cnt;
    logic [15:0]         chan_err_cnt;
    logic [15:0]         ucnt_snap;
`endif

    i2s_tx_if #(.SD_LINES(SD_LINES)) s_axis ();

    i2s_tx #(.CLK_DIV(CLK_DIV), .SD_LINES(SD_LINES)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .s_axis   (s_axis),
        .SCK      (SCK),
        .WS       (WS),
        .SD       (SD),
        .underrun (underrun),
        .chan_err (chan_err)
`ifdef I2S_TX_ERR_CNT_EN
        ,
        .underrun_cnt (underrun_cnt),
        .chan_err_cnt (chan_err_cnt)
`endif
    );

    typedef struct {
        int          slot;
        logic        ch;
        logic [31:0] w0;
        logic [31:0] w1;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   ur_cnt = 0;
    int   ce_cnt = 0;
    int   ur0, ce0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= rstn ? cyc + 1 : 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        total++;
        assert (obs === req)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, req);
        end
    endtask

    function automatic int slot_at(input int m);
        return FIRST + SLOT_CLK * m;
    endfunction

    task automatic push_exp(input int s, input logic c, input logic [31:0] a, input logic [31:0] b);
        exp_q.push_back('{s, c, a & 32'hFFFF_FF00, b & 32'hFFFF_FF00});
    endtask

    task automatic wait_to(input int c);
        do begin
            @(posedge clk);
            #1;
        end while (cyc < c);
    endtask

    task automatic send(input logic u, input logic [31:0] l0, input logic [31:0] l1);
        int n;
        s_axis.tdata  = {l1, l0};
        s_axis.tuser  = u;
        s_axis.tvalid = 1'b1;
        n = 0;
        while (s_axis.tready !== 1'b1 && n < 600) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("send_ready", {31'd0, s_axis.tready}, 32'd1);
        @(posedge clk);
        #1;
        s_axis.tvalid = 1'b0;
    endtask

    // Receiver model: samples on SCK rising edges; a WS change closes the previous slot.
    initial begin
        logic        sck_q, prev_ws;
        logic [31:0] acc0, acc1, w0, w1;
        int          edges;
        exp_t        e;
        sck_q = 1'b0; prev_ws = 1'b1; acc0 = '0; acc1 = '0; edges = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                sck_q = 1'b0; prev_ws = 1'b1; acc0 = '0; acc1 = '0; edges = 0;
            end else begin
                if (underrun === 1'b1) ur_cnt++;
                if (chan_err === 1'b1) ce_cnt++;
                if (SCK === 1'b1 && sck_q === 1'b0) begin
                    if (WS !== prev_ws) begin
                        if (edges > 0) begin
                            w0 = {acc0[30:0], SD[0]};
                            w1 = {acc1[30:0], SD[1]};
                            chk("slot_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                            if (exp_q.size() != 0) begin
                                e = exp_q.pop_front();
                                chk("slot_index", edges - 1, e.slot);
                                chk("slot_ws", {31'd0, prev_ws}, {31'd0, e.ch});
                                chk("slot_sd0", w0, e.w0);
                                chk("slot_sd1", w1, e.w1);
                            end
                        end
                        edges++;
                    end
                    prev_ws = WS;
                    acc0 = {acc0[30:0], SD[0]};
                    acc1 = {acc1[30:0], SD[1]};
                end
                sck_q = SCK;
            end
        end
    end

    initial begin
        logic [31:0] l0, l1;
        rstn          = 1'b0;
        s_axis.tvalid = 1'b0;
        s_axis.tdata  = '0;
        s_axis.tuser  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sck", {31'd0, SCK}, 32'd0);
        chk("rst_ws", {31'd0, WS}, 32'd1);
        chk("rst_sd", {30'd0, SD}, 32'd0);
        chk("rst_tready", {31'd0, s_axis.tready}, 32'd0);
        chk("rst_pulses", {30'd0, underrun, chan_err}, 32'd0);

        // Reset release timing; slot 0 underruns because nothing is buffered.
        push_exp(0, 1'b0, '0, '0);
        rstn = 1'b1;
        wait_to(1);  chk("rel_tready", {31'd0, s_axis.tready}, 32'd1);
                     chk("rel_sck1", {31'd0, SCK}, 32'd0);
        wait_to(3);  chk("rel_sck3", {31'd0, SCK}, 32'd0);
        wait_to(4);  chk("rel_sck4", {31'd0, SCK}, 32'd1);
                     chk("rel_ws4", {31'd0, WS}, 32'd1);
        wait_to(7);  chk("rel_sck7", {31'd0, SCK}, 32'd1);
        wait_to(8);  chk("rel_sck8", {31'd0, SCK}, 32'd0);
                     chk("rel_ws8", {31'd0, WS}, 32'd0);
                     chk("rel_ur8", {31'd0, underrun}, 32'd1);
        wait_to(9);  chk("rel_ur9", {31'd0, underrun}, 32'd0);
        ur0 = ur_cnt;
        ce0 = ce_cnt;

        // Continuous stream, alternating tags.
        for (int m = 1; m <= 6; m++) begin
            wait_to(slot_at(m - 1) + 10);
            l0 = (m < 5) ? 32'h1234_5600 : $urandom;
            l1 = (m < 5) ? ~l0 : $urandom;
            send(m[0], l0, l1);
            push_exp(m, m[0], l0, l1);
        end
        for (int m = 7; m <= 11; m++)
            push_exp(m, m[0], '0, '0);

        // Starvation.
`ifdef I2S_TX_ERR_CNT_EN
        wait_to(slot_at(7) - 1);
        ucnt_snap = underrun_cnt;
`endif
        wait_to(slot_at(7));
        chk("stream_no_ur", ur_cnt - ur0, 0);
        chk("stream_no_ce", ce_cnt - ce0, 0);
        chk("starve_ur_pulse", {31'd0, underrun}, 32'd1);
        wait_to(slot_at(7) + 1);
        chk("starve_ur_width", {31'd0, underrun}, 32'd0);
        wait_to(slot_at(10) + 1);
        chk("starve_ur_count", ur_cnt - ur0, 4);
`ifdef I2S_TX_ERR_CNT_EN
        chk("starve_ur_cnt_reg", {16'd0, underrun_cnt - ucnt_snap}, 32'd4);
`endif

        // Misaligned tag ahead of a left slot.
        wait_to(slot_at(11) + 10);
        send(1'b1, 32'hCAFE_F0AA, 32'h0BAD_1655);
        push_exp(12, 1'b0, '0, '0);
        wait_to(slot_at(12));
        chk("mis_ce_pulse", {31'd0, chan_err}, 32'd1);
        chk("mis_no_ur", {31'd0, underrun}, 32'd0);
        wait_to(slot_at(12) + 1);
        chk("mis_ce_width", {31'd0, chan_err}, 32'd0);
        chk("mis_tready", {31'd0, s_axis.tready}, 32'd1);
        push_exp(13, 1'b1, '0, '0);
        wait_to(slot_at(13) + 10);
        send(1'b0, 32'h89AB_CD11, 32'h7654_3222);
        push_exp(14, 1'b0, 32'h89AB_CD11, 32'h7654_3222);
        wait_to(slot_at(14) + 1);
        chk("mis_ce_total", ce_cnt - ce0, 1);

        // Handshake in the same clk as a slot-start load.
        push_exp(15, 1'b1, '0, '0);
        wait_to(slot_at(15) - 1);
        s_axis.tdata  = {32'h5A5A_5A77, 32'hA5C3_3C88};
        s_axis.tuser  = 1'b0;
        s_axis.tvalid = 1'b1;
        push_exp(16, 1'b0, 32'hA5C3_3C88, 32'h5A5A_5A77);
        wait_to(slot_at(15));
        s_axis.tvalid = 1'b0;
        chk("same_ur_pulse", {31'd0, underrun}, 32'd1);
        chk("same_buffered", {31'd0, s_axis.tready}, 32'd0);
        wait_to(slot_at(16));
        chk("same_load_ok", {30'd0, underrun, chan_err}, 32'd0);

        // Reset at k=15 with a word still buffered.
        wait_to(slot_at(16) + 10);
        send(1'b1, 32'h1111_1100, 32'h2222_2200);
        wait_to(slot_at(17) + 10);
        send(1'b0, 32'h3333_3300, 32'h4444_4400);
        chk("mid_full", {31'd0, s_axis.tready}, 32'd0);
        wait_to(slot_at(17) + 15 * 2 * CLK_DIV + 2);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        chk("mid_rst_sck", {31'd0, SCK}, 32'd0);
        chk("mid_rst_ws", {31'd0, WS}, 32'd1);
        chk("mid_rst_sd", {30'd0, SD}, 32'd0);
        chk("mid_rst_tready", {31'd0, s_axis.tready}, 32'd0);
        chk("mid_rst_pulses", {30'd0, underrun, chan_err}, 32'd0);
`ifdef I2S_TX_ERR_CNT_EN
        chk("mid_rst_cnts", {underrun_cnt, chan_err_cnt}, 32'd0);
`endif
        @(posedge clk);
        #1;
        push_exp(0, 1'b0, '0, '0);
        rstn = 1'b1;
        wait_to(7);
        chk("restart_ws7", {31'd0, WS}, 32'd1);
        wait_to(8);
        chk("restart_ws8", {31'd0, WS}, 32'd0);
        chk("restart_dropped", {31'd0, underrun}, 32'd1);
        wait_to(10);
        send(1'b1, 32'h600D_F00D, 32'hFEED_BEEF);
        push_exp(1, 1'b1, 32'h600D_F00D, 32'hFEED_BEEF);
        wait_to(slot_at(2) + 2 * CLK_DIV);
        chk("all_slots_seen", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
# i2s_tx

I2S master transmitter: accepts per-channel audio words on an AXI-Stream slave and serialises them onto one or more I2S data lines, generating SCK and WS itself. It is the transmit-side counterpart of the sonar I2S receive interface and drives the DAC/transducer path. It uses the same frame format: 32-bit slots, 24-bit left-justified sample, MSB one SCK after the WS edge, and `tuser` as the channel tag.

## Interface
Parameters:
- CLK_DIV, 4: aclk cycles per SCK half-period. SCK period is 2*CLK_DIV. Minimum 2.
- SD_LINES, 2: number of parallel SD outputs. Each line has its own 32-bit lane in tdata.

Ports:
- clk  in  1  AXIS and I2S clock.
- rstn  in  1  reset, synchronous, active-low.
- s_axis_tdata  in  32*SD_LINES  lane n = bits [32n+31:32n]; sample in lane[31:8]; lane[7:0] ignored and transmitted as 0.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  one-word buffer empty.
- s_axis_tuser  in  1  channel tag: 0 = left (WS low), 1 = right (WS high).
- SCK  out  1  bit clock, registered.
- WS  out  1  word select, registered; changes on SCK falling edges only.
- SD  out  SD_LINES  serial data, registered; changes on SCK falling edges only.
- underrun  out  1  one-clk pulse: a slot started with no buffered word.
- chan_err  out  1  one-clk pulse: buffered word's tuser did not match the starting slot; word discarded.

## Operation
- SCK generator: div_cnt counts 0..CLK_DIV-1. At wrap, SCK toggles. A fall strobe is asserted on the clk where SCK goes 1->0.
- bit_cnt (5 bit) advances on each fall strobe. k = 0 marks a slot start (WS edge); k runs 0..31.
- Frame = 2 slots = 64 SCK. Left slot has WS = 0; right slot has WS = 1.
- Fall strobe with k = 0:
  - WS toggles.
  - SD outputs bit 0 of the previous slot's word.
  - The shift register loads from the buffer.
- Fall strobe with k = 1..31: SD[n] = word[n][32-k]. Bits 31..8 come from the lane; bits 7..0 are 0. Only bits 31..1 of the word are sent; the word is shifted one bit in time, per I2S.
- Load at slot start, with the new WS value:
  - Buffer full and tuser == new WS: load lane data, free the buffer.
  - Buffer full and tuser != new WS: load zeros, free the buffer, pulse chan_err. The next correctly tagged beat realigns the stream.
  - Buffer empty: load zeros, pulse underrun.
- Buffer: one word plus its tuser. Handshake is tvalid & tready, with tready = !full.
  - A handshake in the same clk as a load does not bypass into the shift register. That slot reports underrun and the new word waits for the next slot start.
  - A buffered word waits indefinitely until a slot start consumes it.
- Sustained throughput: one beat per 32 SCK, alternating tuser 0, 1, 0, ...

## Timing
- Reset values: SCK = 0, WS = 1, SD = 0, tready = 0, underrun = 0, chan_err = 0, div_cnt = 0, buffer empty.
- bit_cnt resets so that the first fall strobe is k = 0. That strobe drives WS 1->0, so the first slot is left.
- tready = 1 from the first clk after rstn deasserts.
- SCK first rises CLK_DIV clks after reset release and first falls at 2*CLK_DIV.
- SCK, WS, SD, underrun and chan_err all update in the same clk as the fall strobe. The receiver samples on SCK rising edges, half an SCK period later.
- Latency: a beat accepted at least 1 clk before a slot start has its MSB on SD at that slot start + 1 SCK.
- Reset asserted mid-frame returns every register to its reset value on the next clk. The partial slot is abandoned and the buffered word is dropped.

## Configuration
- I2S_TX_ERR_CNT_EN defined: adds outputs underrun_cnt[15:0] and chan_err_cnt[15:0].
  - Each counter saturates at 0xFFFF and increments with its pulse.
  - Both reset to 0 on rstn.
- I2S_TX_ERR_CNT_EN undefined: these ports and counters do not exist. Pulses are unchanged.

## Structure
- Shared i2s_pkg holds: SLOT_W = 32, SAMPLE_W = 24, FRAME_SLOTS = 2, and the channel enum (CH_LEFT = 0, CH_RIGHT = 1). The receiver uses the same package.
- Sub-module i2s_sck_gen (CLK_DIV) outputs SCK and the fall strobe.
- The top level holds bit_cnt, the buffer, the per-line shift registers and the error logic.

## Test plan
All scenarios use CLK_DIV = 4 and SD_LINES = 2; one frame = 512 clk.
- Reset release: SCK rises at clk 4 and falls at clk 8. WS goes 1->0 at clk 8. tready = 1 at clk 1.
- Continuous stream: alternate beats with tuser 0, 1 carrying lane0 = 0x123456_00 and lane1 = ~lane0. Required response:
  - Deserialised SD[0] equals 0x123456 and SD[1] equals 0xEDCBA9 in every slot.
  - No underrun or chan_err pulses.
  - Loopback into the I2S receiver returns identical tdata and tuser.
- Starvation: tvalid held 0.
  - SD = 0 in every slot; underrun pulses once per slot (every 256 clk).
  - Under I2S_TX_ERR_CNT_EN, underrun_cnt = 4 after 2 frames.
- Misaligned tag: first beat has tuser = 1 before a left slot.
  - chan_err pulses at that slot start and the slot is zero.
  - The next tuser 0 beat plays in the following left slot.
- Same-cycle handshake: drive tvalid only in the clk of a k = 0 strobe.
  - underrun pulses for that slot.
  - The word plays in the next matching slot.
- Reset mid-slot at k = 15: all outputs return to reset values, and the frame restarts with a left slot 8 clk after release.
